// File: rtl/uart_rx_word.sv
// uart_rx_word: oversampling UART receiver with word assembly.
// Receives 5..9 data bits, optional even/odd parity and one or two stop bits.
// Consecutive good characters are packed LSB-first into an NB_DATA-wide word.
// A word is published on o_data together with a one-cycle o_valid pulse.
// A character with a parity or framing error is dropped, and the partially
// assembled word is discarded with it.
module uart_rx_word #(
  parameter int F_CLOCK      = 5000000,
  parameter int BAUD_RATE    = 19200,
  parameter int N_OVERSAMPLE = 16,
  parameter int NB_CHAR      = 8,
  parameter int NB_DATA      = 16,
  parameter int TICK_DIV     = F_CLOCK / (BAUD_RATE * N_OVERSAMPLE)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_data,
  input  logic [1:0]         i_parity_mode,
  input  logic               i_two_stop,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int N_CHARS = NB_DATA / NB_CHAR;
  localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW      = $clog2(N_OVERSAMPLE);
  localparam int BW      = $clog2(NB_CHAR);
  localparam int IW      = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(N_OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(N_OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_CHAR - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_CHARS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t               state;
  logic                 sync_meta;
  logic                 sync_line;
  logic                 line_prev;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [IW-1:0]        char_idx;
  logic [NB_CHAR-1:0]   shreg;
  logic [NB_DATA-1:0]   stage;
  logic [NB_DATA-1:0]   word_next;
  logic [1:0]           par_mode_q;
  logic                 two_stop_q;
  logic                 par_err_q;
  logic                 frm_err_q;

  logic tick;
  logic start_edge;
  logic sample_last;
  logic sample_now;
  logic par_en;
  logic par_odd;
  logic finish;
  logic fin_frame_err;
  logic fin_err;

  // A start is a high-to-low transition seen while idle, so a low stop bit
  // cannot retrigger reception until the line has been high again.
  assign tick          = (tick_cnt == TICK_LAST);
  assign start_edge    = (state == S_IDLE) && line_prev && !sync_line;
  assign sample_last   = (state == S_START) ? (sample_cnt == HALF_LAST)
                                            : (sample_cnt == FULL_LAST);
  assign sample_now    = tick && sample_last;
  assign par_en        = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
  assign par_odd       = (par_mode_q == 2'b10);
  assign finish        = sample_now &&
                         (((state == S_STOP1) && !two_stop_q) || (state == S_STOP2));
  assign fin_frame_err = !sync_line || ((state == S_STOP2) && frm_err_q);
  assign fin_err       = fin_frame_err || par_err_q;

  // Current staging word with the just-received character merged in.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    word_next = stage;
    word_next[char_idx*NB_CHAR +: NB_CHAR] = shreg;
  end

  // Two-flop synchronizer plus previous-value register for edge detection;
  // all three idle high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!i_reset) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_meta <= i_data;
      sync_line <= sync_meta;
      line_prev <= sync_line;
    end
  end

  // Free-running tick divider, realigned to the start edge so samples land
  // at a fixed phase within each bit.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      tick_cnt <= '0;
    end else if (start_edge || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Receive FSM, character assembly and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= S_IDLE;
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      char_idx     <= '0;
      shreg        <= '0;
      stage        <= '0;
      par_mode_q   <= 2'b00;
      two_stop_q   <= 1'b0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;

      // Tick counting within the current bit; wraps at each sample point.
      if (state != S_IDLE && tick) begin
        sample_cnt <= sample_last ? '0 : sample_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state      <= S_START;
            o_busy     <= 1'b1;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            par_mode_q <= i_parity_mode;
            two_stop_q <= i_two_stop;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
          end
        end

        S_START: begin
          // Mid-start-bit re-check rejects short low glitches.
          if (sample_now) begin
            if (sync_line) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (sample_now) begin
            shreg <= {sync_line, shreg[NB_CHAR-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= par_en ? S_PARITY : S_STOP1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (sample_now) begin
            par_err_q <= ((^shreg) ^ sync_line) != par_odd;
            state     <= S_STOP1;
          end
        end

        S_STOP1: begin
          if (sample_now && two_stop_q) begin
            frm_err_q <= !sync_line;
            state     <= S_STOP2;
          end
        end

        S_STOP2: begin
          // Completion handled below with the other finish actions.
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase

      // Frame completion: report errors or commit the character.
      if (finish) begin
        state        <= S_IDLE;
        o_busy       <= 1'b0;
        o_parity_err <= par_err_q;
        o_frame_err  <= fin_frame_err;
        if (fin_err) begin
          char_idx <= '0;
        end else if (char_idx == IDX_LAST) begin
          o_data   <= word_next;
          o_valid  <= 1'b1;
          char_idx <= '0;
          stage    <= '0;
        end else begin
          stage    <= word_next;
          char_idx <= char_idx + 1'b1;
        end
      end
    end
  end

endmodule
